mem_burst_loader: RTL

- Burst sequencer directly upstream of the accelerator MemoryManager (weights / intermediate / I/O buffer banks).
- Accepts one command descriptor at a time: bank select, base address, word count.
- Write bursts: drains a valid/ready input stream into consecutive MemoryManager write cycles.
- Read-back bursts: fetches consecutive words and presents them on a valid/ready output stream, absorbing the memory's one-cycle read latency and downstream backpressure.

---
 rtl/mem_burst_loader.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/mem_burst_loader.sv
// Burst sequencer in front of the MemoryManager: streams write bursts into a bank
// and reads bursts back out through a 2-entry skid FIFO that hides the read latency.
module mem_burst_loader #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [1:0]        cmd_sel,
    input  logic [ADDR_W-1:0] cmd_base,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] mem_data_in,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_write_enable,
    output logic [1:0]        mem_select,
    input  logic [DATA_W-1:0] mem_data_out,
    output logic              busy,
    output logic              done,
    output logic              err
);
    typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

    state_t            state;
    logic [1:0]        sel_q;
    logic [ADDR_W-1:0] base_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  cnt_q;
    logic              done_q;
    logic              err_q;
    logic              vld_p1;
    logic [DATA_W-1:0] fifo_q [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        occ;

    logic              wr_fire;
    logic              rd_issue;
    logic              push;
    logic              pop;
    logic              last_cnt;
    logic [ADDR_W-1:0] cur_addr;
    logic [2:0]        committed;

    assign cur_addr = base_q + ADDR_W'(cnt_q);
    assign last_cnt = (cnt_q + LEN_W'(1)) == len_q;
    assign pop      = (occ != 2'd0) && m_ready;
    assign push     = vld_p1;
    assign wr_fire  = (state == WRITE) && s_valid;

    // A word popped this cycle frees its slot, so back-to-back issue sustains full rate.
    assign committed = {1'b0, occ} + {2'b00, vld_p1} - {2'b00, pop};
    assign rd_issue  = (state == READ) && (committed < 3'd2);

    assign cmd_ready        = (state == IDLE);
    assign busy             = (state != IDLE);
    assign s_ready          = (state == WRITE);
    assign m_valid          = (occ != 2'd0);
    assign m_data           = m_valid ? fifo_q[rd_ptr] : '0;
    assign mem_write_enable = wr_fire;
    assign mem_data_in      = wr_fire ? s_data : '0;
    assign mem_address      = (wr_fire || rd_issue) ? cur_addr : '0;
    assign mem_select       = (state == IDLE) ? 2'b00 : sel_q;
    assign done             = done_q;
    assign err              = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt_q  <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            vld_p1 <= 1'b0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= 2'd0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            // p0 -> p1: address issued this cycle, data returns next cycle
            vld_p1 <= rd_issue;
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            occ <= occ + 2'(push) - 2'(pop);
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_sel == 2'b11) begin
                            err_q <= 1'b1;
                        end else if (cmd_len == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            cnt_q <= '0;
                            state <= cmd_write ? WRITE : READ;
                        end
                    end
                end
                WRITE: begin
                    if (wr_fire) begin
                        cnt_q <= cnt_q + LEN_W'(1);
                        if (last_cnt) begin
                            state  <= IDLE;
                            done_q <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (rd_issue) begin
                        cnt_q <= cnt_q + LEN_W'(1);
                        if (last_cnt) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!vld_p1 && (occ == 2'd0 || (occ == 2'd1 && pop))) begin
                        state  <= IDLE;
                        done_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && cmd_valid) begin
            sel_q  <= cmd_sel;
            base_q <= cmd_base;
            len_q  <= cmd_len;
        end
        // p1: capture returning read data
        if (push) fifo_q[wr_ptr] <= mem_data_out;
    end
endmodule
